// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with a start/done handshake.
// Load N on start, decrement once per unpaused cycle while running, then
// present a single-cycle done. Used by the multiply/divide sequencers to
// bound their iteration count.
module countdown_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    // State and count registers; reset clears both without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Next-state and next-count decode; priority is abort, start, pause, decrement.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        if (abort) begin
            // Cancel silently: no done pulse on the way back to IDLE.
            state_next = IDLE;
            count_next = '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        // A zero load skips RUN and expires immediately.
                        count_next = load_val;
                        state_next = (load_val != '0) ? RUN : DONE;
                    end else if (state_reg == DONE) begin
                        // DONE is a one-cycle pulse; count is already 0 here.
                        state_next = IDLE;
                        count_next = '0;
                    end
                end
                RUN: begin
                    if (!pause) begin
                        // Compare against <= 1 so a corrupted 0 can never wrap.
                        if (count_reg <= WIDTH'(1)) begin
                            state_next = DONE;
                            count_next = '0;
                        end else begin
                            count_next = count_reg - WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    // Outputs come straight from registered state.
    assign count = count_reg;
    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with a start/done handshake. It is the counting-down counterpart of the free-running 3-bit up-counter. The multiply/divide sequencers use it to run a fixed number of iteration cycles: load N, count to zero, and pulse `done` on expiry. It sits beside the datapath and drives the sequencer's "last iteration" decision.

## Interface
- `WIDTH`, default 6: counter width. Supports N = 0..2^WIDTH-1; 32 iterations is the primary use.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to load `load_val` and begin counting. Accepted only in IDLE or DONE.
- `load_val`  in  WIDTH  iteration count N, sampled on the accepting edge only.
- `pause`  in  1  freezes the count while high (RUN only).
- `abort`  in  1  synchronous cancel; returns the block to IDLE.
- `count`  out  WIDTH  remaining iterations.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the count expires.

## Operation
- **States.** IDLE, RUN, DONE. Outputs are registered or derived from the state only:
  - `busy` = (state == RUN)
  - `done` = (state == DONE)
- **Reset (asynchronous, any state).** state = IDLE, `count` = 0, `busy` = 0, `done` = 0. No clock is needed for reset to take effect.
- **IDLE.**
  - `start` = 1: `count` <= `load_val`.
    - If `load_val` != 0, next state is RUN.
    - If `load_val` == 0, next state is DONE.
  - `start` = 0: hold; `count` stays unchanged.
- **RUN.**
  - `pause` = 1: hold everything.
  - `pause` = 0: `count` <= `count` - 1.
  - If `count` == 1 and `pause` = 0, next state is DONE, with `count` becoming 0.
  - `start` is ignored in RUN. There is no reload mid-run.
- **DONE.** Lasts exactly one cycle.
  - `start` = 1: behaves exactly as `start` in IDLE. This allows back-to-back runs with no idle gap.
  - Otherwise: next state is IDLE and `count` stays 0.
- **Priority on a single edge:** `abort` > `start` > `pause` > decrement.
- **`abort`.** Forces IDLE with `count` = 0 from any state. It produces no `done` pulse.
- **Arithmetic.** Unsigned, modulo-free. `count` never decrements below 0; reaching state DONE guarantees `count` = 0. Underflow wrap to 2^WIDTH-1 is forbidden.
- **Inputs.** `load_val` is ignored except on an accepting edge. `pause` is ignored outside RUN.

## Timing
- **Load latency.** `start` is sampled at edge k, so `count` = N is visible after edge k.
- **Expiry latency.** With N > 0 and no pause:
  - `busy` is high for exactly N cycles, from edge k to edge k+N.
  - `done` is high from edge k+N to edge k+N+1.
  - `count` takes the values N, N-1, …, 1 during RUN, then 0 in DONE.
- **N = 0.** `done` is high for the single cycle after edge k and `busy` never rises.
- **Pause.** Each cycle with `pause` high in RUN extends `busy` and delays `done` by exactly one cycle.
- **Back-to-back.** `start` during the DONE cycle gives `busy` = 1 in the very next cycle, so the gap between runs is 1 cycle (the DONE cycle).
- **Reset mid-run.** Asserting `reset` between edges immediately drops `busy`, `done` and `count` to 0. After `reset` deasserts, the first accepted `start` behaves normally.

## Test plan
- **Reset.** Assert `reset` asynchronously with no clock edge. Required: `count` = 0, `busy` = 0, `done` = 0 immediately. Release `reset`, idle 3 cycles: outputs stay 0.
- **Basic countdown.** `start` with `load_val` = 5 at edge k. Required:
  - `count` = 5,4,3,2,1 after edges k..k+4;
  - `busy` = 1 for those 5 cycles;
  - after edge k+5: `done` = 1 for one cycle with `count` = 0;
  - then IDLE.
- **Zero load and maximum load.**
  - `load_val` = 0: `done` pulses after edge k and `busy` stays 0.
  - `load_val` = 63: `busy` lasts 63 cycles and `count` never shows 63→… past 0 (no wrap).
- **Pause and ignored start.**
  - `load_val` = 4 with `pause` high for 2 cycles while `count` = 3: `count` holds at 3, and `done` arrives 2 cycles later than without the pause (6 cycles after `start`).
  - `start` with `load_val` = 9 during RUN: no effect on `count`.
- **Back-to-back and abort.**
  - `start` (`load_val` = 2) asserted in the DONE cycle of a previous run: `count` = 2 on the next edge and `busy` stays high with a 1-cycle gap.
  - `abort` at `count` = 1 while `start` is also high: IDLE, `count` = 0, no `done` pulse.
- **Reset mid-run.** `load_val` = 32; assert `reset` asynchronously at `count` = 17. Required: all outputs 0 immediately. A fresh `start` (`load_val` = 3) then completes normally, with `done` 3 cycles after the start edge.
